divider_scheduler: RTL and testbench

DIVIDER_SCHEDULER -- requirements
Module: divider_scheduler

---
 rtl/divider_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/divider_scheduler.sv | 135 +++++++++++++
 tb/tb_divider_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the divider scheduler.
//   state_t          - scheduler FSM state encoding
//   DIV0_QUOTIENT    - result returned for a zero divisor
//   TIMEOUT_QUOTIENT - result returned when the divider never answers
//   OPERAND_W        - width of one packed dividend/divisor slot
package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  localparam logic [31:0] DIV0_QUOTIENT    = 32'hFFFF_FFFF;
  localparam logic [31:0] TIMEOUT_QUOTIENT = 32'h0000_0000;
  localparam int unsigned OPERAND_W        = 64;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant among N_REQ requesters.
//   clk, reset - clock and asynchronous active-low reset
//   req        - request vector
//   accept     - grant is taken this cycle; advance the priority pointer
//   grant      - one-hot grant (combinational), zero when no request
// Priority starts at the requester after the last accepted one; after reset
// requester 0 is highest.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        next_ptr    = IDX_W'((32'(idx) + 1) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (accept && found) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/divider_scheduler.sv
// divider_scheduler: shares one binary divider among N_REQ requesters.
//   clk, reset                 - clock and asynchronous active-low reset
//   req_valid/req_ready        - per-requester request, one-cycle accept pulse
//   req_dividend/req_divisor   - packed 64-bit operands, slot i at [64*i +: 64]
//   rsp_valid                  - one-cycle result pulse to the owning requester
//   rsp_quotient/rsp_err       - result and error flag, held until next result
//   div_en                     - one-cycle start pulse to the divider
//   g_dividend_Q/g_divider_Q   - operands to the divider, held through the op
//   quotient/done              - divider result and completion
// A zero divisor is answered directly without starting the divider; a divider
// that stays silent for TIMEOUT cycles after the start is answered with an
// error, and any later done is ignored.
module divider_scheduler
  import divider_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*OPERAND_W-1:0] req_dividend,
  input  logic [N_REQ*OPERAND_W-1:0] req_divisor,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [31:0]                rsp_quotient,
  output logic                       rsp_err,
  output logic                       div_en,
  output logic [OPERAND_W-1:0]       g_dividend_Q,
  output logic [OPERAND_W-1:0]       g_divider_Q,
  input  logic [31:0]                quotient,
  input  logic                       done
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t               state;
  logic [N_REQ-1:0]     grant;
  logic [N_REQ-1:0]     owner;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 accept;
  logic [OPERAND_W-1:0] sel_dividend;
  logic [OPERAND_W-1:0] sel_divisor;

  assign accept = (state == S_IDLE) && (|req_valid);

  // req_ready is the combinational accept so the pulse lands in the same
  // cycle the grant is decided; it is forced low while reset is held.
  assign req_ready = (accept && reset) ? grant : '0;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_dividend = req_dividend[OPERAND_W*i +: OPERAND_W];
        sel_divisor  = req_divisor[OPERAND_W*i +: OPERAND_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      owner        <= '0;
      rsp_valid    <= '0;
      rsp_quotient <= '0;
      rsp_err      <= 1'b0;
      div_en       <= 1'b0;
      g_dividend_Q <= '0;
      g_divider_Q  <= '0;
      wait_cnt     <= '0;
    end else begin
      div_en    <= 1'b0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner <= grant;
            if (sel_divisor == '0) begin
              rsp_valid    <= grant;
              rsp_quotient <= DIV0_QUOTIENT;
              rsp_err      <= 1'b1;
              state        <= S_RESPOND;
            end else begin
              g_dividend_Q <= sel_dividend;
              g_divider_Q  <= sel_divisor;
              div_en       <= 1'b1;
              state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Counts cycles since the start pulse; the ISSUE cycle is cycle 0.
          wait_cnt <= CNT_W'(1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            rsp_valid    <= owner;
            rsp_quotient <= quotient;
            rsp_err      <= 1'b0;
            wait_cnt     <= '0;
            state        <= S_RESPOND;
          end else if (wait_cnt >= CNT_W'(TIMEOUT - 1)) begin
            rsp_valid    <= owner;
            rsp_quotient <= TIMEOUT_QUOTIENT;
            rsp_err      <= 1'b1;
            wait_cnt     <= '0;
            state        <= S_RESPOND;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_RESPOND: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_scheduler.sv
// Self-checking bench for divider_scheduler: a cycle-level transaction model
// predicts grants, start pulses and responses from the round-robin, timeout
// and divide-by-zero rules; a mock divider answers with programmable latency.
module tb_divider_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*64-1:0] req_dividend = '0;
  logic [N*64-1:0] req_divisor = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_quotient;
  logic            rsp_err;
  logic            div_en;
  logic [63:0]     g_dividend_Q;
  logic [63:0]     g_divider_Q;
  logic [31:0]     quotient_in = '0;
  logic            done_in = 1'b0;

  divider_scheduler #(
    .N_REQ   (N),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .req_valid    (req_valid),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_quotient (rsp_quotient),
    .rsp_err      (rsp_err),
    .div_en       (div_en),
    .g_dividend_Q (g_dividend_Q),
    .g_divider_Q  (g_divider_Q),
    .quotient     (quotient_in),
    .done         (done_in)
  );

  always #5 clk = ~clk;

  // Mock divider: done arrives div_lat cycles after the start cycle; 0 = never.
  int          div_lat = 3;
  bit          rand_lat = 1'b0;
  int          dcnt = 0;
  logic [31:0] q_hold = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt    <= 0;
      done_in <= 1'b0;
    end else begin
      done_in     <= 1'b0;
      quotient_in <= $urandom;
      if (div_en) begin
        q_hold <= (g_divider_Q != 0) ? 32'(g_dividend_Q / g_divider_Q) : '1;
        if (div_lat == 1) begin
          done_in     <= 1'b1;
          quotient_in <= (g_divider_Q != 0) ? 32'(g_dividend_Q / g_divider_Q) : '1;
        end else if (div_lat > 1) begin
          dcnt <= div_lat - 1;
        end
      end else if (dcnt == 1) begin
        done_in     <= 1'b1;
        quotient_in <= q_hold;
        dcnt        <= 0;
      end else if (dcnt > 1) begin
        dcnt <= dcnt - 1;
      end
    end
  end

  // Reference model state
  int           checks = 0;
  int           passes = 0;
  int           fails = 0;
  int           cyc = 0;
  logic [N-1:0] pending = '0;
  logic [N-1:0] hold = '0;
  logic [63:0]  m_a [N];
  logic [63:0]  m_b [N];
  int           last = int'(N) - 1;
  bit           busy = 1'b0;
  int           owner = 0;
  int           exp_div_cyc = -1;
  int           exp_rsp_cyc = -1;
  logic [31:0]  exp_q = '0;
  logic         exp_err = 1'b0;
  logic [31:0]  last_q = '0;
  logic         last_err = 1'b0;
  int           div_en_seen = 0;
  int           dut_grants [$];
  int           dut_owners [$];
  logic [31:0]  dut_q [$];
  logic         dut_err [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] p, input int lst);
    for (int k = 1; k <= int'(N); k++) begin
      int i;
      i = (lst + k) % int'(N);
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_log();
    dut_grants.delete();
    dut_owners.delete();
    dut_q.delete();
    dut_err.delete();
    div_en_seen = 0;
  endtask

  task automatic add_req(input int i, input logic [63:0] a, input logic [63:0] b);
    m_a[i] = a;
    m_b[i] = b;
    pending[i] = 1'b1;
    req_dividend[64*i +: 64] = a;
    req_divisor[64*i +: 64]  = b;
    req_valid = pending;
  endtask

  // One clock: sample and compare at the falling edge, update inputs after the rising edge.
  task automatic step();
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    int           g;
    @(negedge clk);
    cyc++;
    if (busy && exp_div_cyc >= 0 && done_in === 1'b1 && cyc > exp_div_cyc &&
        cyc < exp_div_cyc + int'(TMO) && exp_rsp_cyc > cyc) begin
      exp_rsp_cyc = cyc + 1;
      exp_q       = 32'(m_a[owner] / m_b[owner]);
      exp_err     = 1'b0;
    end
    exp_ready = '0;
    g = -1;
    if (!busy) begin
      g = rr_pick(pending, last);
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", req_ready, exp_ready);
    for (int i = 0; i < int'(N); i++) if (req_ready[i]) dut_grants.push_back(i);
    if (div_en) div_en_seen++;
    check("div_en", div_en, (busy && cyc == exp_div_cyc));
    if (busy && cyc == exp_div_cyc) begin
      check("g_dividend_Q", g_dividend_Q, m_a[owner]);
      check("g_divider_Q", g_divider_Q, m_b[owner]);
    end
    if (rsp_valid != 0) begin
      for (int i = 0; i < int'(N); i++) if (rsp_valid[i]) dut_owners.push_back(i);
      dut_q.push_back(rsp_quotient);
      dut_err.push_back(rsp_err);
    end
    if (busy && cyc == exp_rsp_cyc) begin
      exp_rv = '0;
      exp_rv[owner] = 1'b1;
      check("rsp_valid", rsp_valid, exp_rv);
      last_q   = exp_q;
      last_err = exp_err;
      busy     = 1'b0;
    end else begin
      check("rsp_valid_quiet", rsp_valid, '0);
    end
    check("rsp_quotient", rsp_quotient, last_q);
    check("rsp_err", rsp_err, last_err);
    if (g >= 0) begin
      busy  = 1'b1;
      owner = g;
      last  = g;
      if (m_b[g] == 0) begin
        exp_div_cyc = -1;
        exp_rsp_cyc = cyc + 1;
        exp_q       = 32'hFFFF_FFFF;
        exp_err     = 1'b1;
      end else begin
        exp_div_cyc = cyc + 1;
        exp_rsp_cyc = cyc + 1 + int'(TMO);
        exp_q       = 32'h0;
        exp_err     = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0 && !hold[g]) pending[g] = 1'b0;
    if (rand_lat) div_lat = int'($urandom_range(1, 14));
    req_valid = pending;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((busy || pending != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_bound", (busy || pending != 0), 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_div_en", div_en, 1'b0);
    check("rst_rsp_quotient", rsp_quotient, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_g_dividend", g_dividend_Q, '0);
    check("rst_g_divider", g_divider_Q, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy = 1'b0;
    last = int'(N) - 1;
    last_q = '0;
    last_err = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    do_reset();
    repeat (2) step();

    // All four requesters at once: served 0..3 in order.
    clear_log();
    div_lat = 3;
    add_req(0, 64'd100, 64'd10);
    add_req(1, 64'd200, 64'd10);
    add_req(2, 64'd300, 64'd10);
    add_req(3, 64'd400, 64'd10);
    drain(200);
    check("all4_count", dut_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < dut_grants.size()) check($sformatf("all4_grant%0d", k), dut_grants[k], k);
      if (k < dut_owners.size()) check($sformatf("all4_owner%0d", k), dut_owners[k], k);
      if (k < dut_q.size()) check($sformatf("all4_q%0d", k), dut_q[k], 10 * (k + 1));
    end

    // Fairness with requesters 0 and 2 held.
    clear_log();
    div_lat = 2;
    hold = 4'b0101;
    add_req(0, 64'd50, 64'd5);
    add_req(2, 64'd90, 64'd3);
    for (int n = 0; n < 200 && dut_grants.size() < 4; n++) step();
    hold = '0;
    drain(200);
    check("fair_count", (dut_grants.size() >= 4), 1'b1);
    for (int k = 0; k < 4; k++)
      if (k < dut_grants.size()) check($sformatf("fair_grant%0d", k), dut_grants[k], (k % 2) * 2);

    // Single request 765/63.
    clear_log();
    div_lat = 5;
    add_req(0, 64'd765, 64'd63);
    drain(100);
    check("single_count", dut_q.size(), 1);
    if (dut_q.size() > 0) begin
      check("single_q", dut_q[0], 12);
      check("single_err", dut_err[0], 1'b0);
      check("single_owner", dut_owners[0], 0);
    end

    // Divide by zero: answered without touching the divider.
    clear_log();
    add_req(1, 64'd5, 64'd0);
    drain(50);
    repeat (2) step();
    check("div0_no_div_en", div_en_seen, 0);
    check("div0_count", dut_q.size(), 1);
    if (dut_q.size() > 0) begin
      check("div0_q", dut_q[0], 32'hFFFF_FFFF);
      check("div0_err", dut_err[0], 1'b1);
      check("div0_owner", dut_owners[0], 1);
    end

    // Timeout with a late done, plus a request withdrawn before its grant.
    clear_log();
    div_lat = 20;
    add_req(2, 64'd1000, 64'd7);
    repeat (5) step();
    add_req(3, 64'd44, 64'd4);
    repeat (2) step();
    pending[3] = 1'b0;
    req_valid = pending;
    drain(100);
    repeat (8) step();
    check("tmo_count", dut_q.size(), 1);
    check("tmo_grants", dut_grants.size(), 1);
    if (dut_q.size() > 0) begin
      check("tmo_q", dut_q[0], 0);
      check("tmo_err", dut_err[0], 1'b1);
      check("tmo_owner", dut_owners[0], 2);
    end

    // Boundary: done on the last waiting cycle is taken, one later is not.
    clear_log();
    div_lat = 15;
    add_req(0, 64'd900, 64'd9);
    drain(100);
    div_lat = 16;
    add_req(1, 64'd900, 64'd9);
    drain(100);
    repeat (3) step();
    check("edge_count", dut_q.size(), 2);
    if (dut_q.size() > 1) begin
      check("edge15_q", dut_q[0], 100);
      check("edge15_err", dut_err[0], 1'b0);
      check("edge16_q", dut_q[1], 0);
      check("edge16_err", dut_err[1], 1'b1);
    end

    // Reset while waiting on the divider.
    clear_log();
    div_lat = 0;
    add_req(0, 64'd765, 64'd63);
    repeat (4) step();
    add_req(3, 64'd800, 64'd8);
    do_reset();
    check("rst_no_rsp", dut_owners.size(), 0);
    div_lat = 4;
    repeat (2) step();
    add_req(0, 64'd765, 64'd63);
    drain(200);
    check("rst_after_count", dut_q.size(), 2);
    if (dut_q.size() > 1) begin
      check("rst_after_q3", dut_q[0], 100);
      check("rst_after_q0", dut_q[1], 12);
      check("rst_after_owner0", dut_owners[1], 0);
    end

    // Randomized traffic with random latencies and occasional zero divisors.
    rand_lat = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        if ($urandom_range(0, 1) == 1) begin
          logic [63:0] a;
          logic [63:0] b;
          a = {$urandom, $urandom};
          b = ($urandom_range(0, 4) == 0) ? 64'd0 : {32'($urandom_range(0, 3)), $urandom | 32'd1};
          add_req(i, a, b);
        end
      end
      repeat (int'($urandom_range(0, 6))) step();
      drain(600);
      step();
    end
    rand_lat = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "simulation did not finish");
  end

endmodule
